// File: rtl/fan_dwell_controller_if.sv
// Signal bundle between the thermostat comparator side and the fan dwell controller.
// There is no valid/ready handshake: every signal is a level. The controller samples
// fanOn, presetTemp and currentTemp on every rising clock edge, and its outputs hold a
// stable value for the whole cycle after each edge.
interface fan_dwell_controller_if;
  logic       fanOn;
  logic [2:0] presetTemp;
  logic [2:0] currentTemp;
  logic       fanEnable;
  logic       fanPwm;
  logic [2:0] fanDuty;
  logic [1:0] fanState;
  logic       dwellBusy;

  // Request/temperature source (comparator side or testbench)
  modport master (
    output fanOn, presetTemp, currentTemp,
    input  fanEnable, fanPwm, fanDuty, fanState, dwellBusy
  );

  // Fan dwell controller
  modport slave (
    input  fanOn, presetTemp, currentTemp,
    output fanEnable, fanPwm, fanDuty, fanState, dwellBusy
  );
endinterface

// File: rtl/fan_dwell_controller.sv
// Fan dwell controller: debounces the comparator's fanOn request, applies a full-power
// spin-up burst on every start, enforces minimum on/off dwell times so the fan never
// short-cycles, and drives a 7-step PWM whose duty follows the temperature excess.
// All outputs decode from registered state; inputs never reach outputs combinationally.
module fan_dwell_controller #(
  parameter int FILTER_LEN     = 3,
  parameter int SPINUP_CYCLES  = 4,
  parameter int MIN_ON_CYCLES  = 16,
  parameter int MIN_OFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input logic                   clk,
  input logic                   reset,
  fan_dwell_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_SPINUP   = 2'b01,
    ST_RUN      = 2'b10,
    ST_HOLD_OFF = 2'b11
  } state_t;

  // Terminal counter values, sized to the counter width once
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPINUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYCLES - 1);
  localparam logic [2:0]       PWM_LAST  = 3'd6;

  state_t           state_q, state_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0] on_timer_q, on_timer_d;
  logic [CNT_W-1:0] off_timer_q, off_timer_d;
  logic [2:0]       pwm_cnt_q, pwm_cnt_d;
  logic [2:0]       duty_q, duty_d;

  logic             fan_enable;
  logic             fan_pwm;
  logic [2:0]       fan_duty;
  logic             dwell_busy;

  // Request debounce: filt only follows fanOn after FILTER_LEN consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (bus.fanOn != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d     = ~filt_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Duty target from the temperature excess, never below 1/7 while running.
  // Registered so the fan outputs depend on no input combinationally.
  always_comb begin
    logic [2:0] delta;
    delta = 3'd0;
    if (bus.currentTemp > bus.presetTemp) begin
      delta = bus.currentTemp - bus.presetTemp;
    end
    duty_d = (delta == 3'd0) ? 3'd1 : delta;
  end

  // Free-running PWM phase counter, period 7 (0..6)
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 3'd0 : pwm_cnt_q + 3'd1;
  end

  // Dwell FSM next-state and timer updates. The FSM looks at the registered filt, so a
  // request must already be settled in filt before an edge to steer that edge.
  always_comb begin
    state_d     = state_q;
    on_timer_d  = on_timer_q;
    off_timer_d = off_timer_q;
    case (state_q)
      ST_OFF: begin
        if (filt_q) begin
          state_d    = ST_SPINUP;
          on_timer_d = '0;
        end
      end
      ST_SPINUP: begin
        // Request changes are ignored until the burst is done
        if (on_timer_q != ON_LAST) begin
          on_timer_d = on_timer_q + 1'b1;
        end
        if (on_timer_q == SPIN_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (on_timer_q != ON_LAST) begin
          on_timer_d = on_timer_q + 1'b1;
        end
        if (!filt_q && (on_timer_q == ON_LAST)) begin
          state_d     = ST_HOLD_OFF;
          off_timer_d = '0;
        end
      end
      ST_HOLD_OFF: begin
        // Request changes are ignored until the off dwell is served; a pending start
        // then goes straight to SPINUP without passing through OFF.
        if (off_timer_q != OFF_LAST) begin
          off_timer_d = off_timer_q + 1'b1;
        end
        if (off_timer_q == OFF_LAST) begin
          if (filt_q) begin
            state_d    = ST_SPINUP;
            on_timer_d = '0;
          end else begin
            state_d = ST_OFF;
          end
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // State and counter registers; reset wins over every other event
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OFF;
      filt_q      <= 1'b0;
      filt_cnt_q  <= '0;
      on_timer_q  <= '0;
      off_timer_q <= '0;
      pwm_cnt_q   <= 3'd0;
      duty_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      on_timer_q  <= on_timer_d;
      off_timer_q <= off_timer_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
    end
  end

  // Output decode from registered state, timers and PWM phase only
  always_comb begin
    fan_enable = 1'b0;
    fan_pwm    = 1'b0;
    fan_duty   = 3'd0;
    dwell_busy = 1'b0;
    case (state_q)
      ST_SPINUP: begin
        fan_enable = 1'b1;
        fan_pwm    = 1'b1;
        dwell_busy = 1'b1;
      end
      ST_RUN: begin
        fan_enable = 1'b1;
        fan_duty   = duty_q;
        fan_pwm    = (pwm_cnt_q < duty_q);
        dwell_busy = (on_timer_q < ON_LAST);
      end
      ST_HOLD_OFF: begin
        dwell_busy = 1'b1;
      end
      default: begin
        fan_enable = 1'b0;
      end
    endcase
  end

  assign bus.fanEnable = fan_enable;
  assign bus.fanPwm    = fan_pwm;
  assign bus.fanDuty   = fan_duty;
  assign bus.fanState  = state_q;
  assign bus.dwellBusy = dwell_busy;

endmodule
